// File: rtl/decoder.sv
// Morse character decoder: four right-aligned 2-bit symbol slots to uppercase ASCII,
// registered with one clock of latency. Malformed or unassigned patterns yield '?'.
module decoder (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] morse_array,
    output logic [7:0] decoded_char
);

    logic [7:0] decoded_q;
    logic [7:0] decoded_d;
    logic [2:0] len;
    logic [3:0] dashes;
    logic [1:0] sym;
    logic       valid;
    logic       seen;

    always_comb begin
        len    = '0;
        valid  = 1'b1;
        seen   = 1'b0;
        sym    = '0;
        // Upper bit of each slot is 1 for a dash; empty leading slots contribute 0.
        dashes = {morse_array[7], morse_array[5], morse_array[3], morse_array[1]};

        for (int unsigned i = 0; i < 4; i++) begin
            sym = morse_array[6 - 2*i +: 2];
            case (sym)
                2'b11: valid = 1'b0;
                2'b00: if (seen) valid = 1'b0;
                default: begin
                    seen = 1'b1;
                    len  = len + 3'd1;
                end
            endcase
        end

        decoded_d = 8'h3F;
        if (!valid) begin
            decoded_d = 8'h3F;
        end else if (len == 3'd0) begin
            decoded_d = 8'h00;
        end else begin
            // Key is {symbol count, dash pattern in transmission order, right-aligned}.
            case ({len, dashes})
                7'b001_0000: decoded_d = 8'h45; // E
                7'b001_0001: decoded_d = 8'h54; // T
                7'b010_0001: decoded_d = 8'h41; // A
                7'b010_0000: decoded_d = 8'h49; // I
                7'b010_0011: decoded_d = 8'h4D; // M
                7'b010_0010: decoded_d = 8'h4E; // N
                7'b011_0100: decoded_d = 8'h44; // D
                7'b011_0110: decoded_d = 8'h47; // G
                7'b011_0101: decoded_d = 8'h4B; // K
                7'b011_0111: decoded_d = 8'h4F; // O
                7'b011_0010: decoded_d = 8'h52; // R
                7'b011_0000: decoded_d = 8'h53; // S
                7'b011_0001: decoded_d = 8'h55; // U
                7'b011_0011: decoded_d = 8'h57; // W
                7'b100_1000: decoded_d = 8'h42; // B
                7'b100_1010: decoded_d = 8'h43; // C
                7'b100_0010: decoded_d = 8'h46; // F
                7'b100_0000: decoded_d = 8'h48; // H
                7'b100_0111: decoded_d = 8'h4A; // J
                7'b100_0100: decoded_d = 8'h4C; // L
                7'b100_0110: decoded_d = 8'h50; // P
                7'b100_1101: decoded_d = 8'h51; // Q
                7'b100_0001: decoded_d = 8'h56; // V
                7'b100_1001: decoded_d = 8'h58; // X
                7'b100_1011: decoded_d = 8'h59; // Y
                7'b100_1100: decoded_d = 8'h5A; // Z
                default:     decoded_d = 8'h3F;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            decoded_q <= '0;
        end else begin
            decoded_q <= decoded_d;
        end
    end

    assign decoded_char = decoded_q;

endmodule

// File: tb/tb_decoder.sv
// Self-checking bench for decoder: directed cases, reset behaviour, full sweep and
// random stimulus compared against a string-based Morse table model.
module tb_decoder;

    logic       clk;
    logic       rst;
    logic [7:0] morse_array;
    logic [7:0] decoded_char;

    int unsigned errors = 0;
    int unsigned checks = 0;
    logic [7:0]  prev_exp;

    decoder u_dut (
        .clk          (clk),
        .rst          (rst),
        .morse_array  (morse_array),
        .decoded_char (decoded_char)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    string morse_tab [26] = '{
        ".-",   "-...", "-.-.", "-..",  ".",    "..-.", "--.",  "....", "..",
        ".---", "-.-",  ".-..", "--",   "-.",   "---",  ".--.", "--.-", ".-.",
        "...",  "-",    "..-",  "...-", ".--",  "-..-", "-.--", "--.."
    };

    function automatic logic [7:0] ref_decode(input logic [7:0] v);
        string      code;
        bit         started;
        logic [1:0] s;
        code    = "";
        started = 1'b0;
        for (int k = 3; k >= 0; k--) begin
            s = 2'(v >> (2 * k));
            if (s == 2'b11) return 8'h3F;
            if (s == 2'b00) begin
                if (started) return 8'h3F;
            end else begin
                started = 1'b1;
                code = {code, (s == 2'b01) ? "." : "-"};
            end
        end
        if (code.len() == 0) return 8'h00;
        for (int j = 0; j < 26; j++) begin
            if (morse_tab[j] == code) return 8'(65 + j);
        end
        return 8'h3F;
    endfunction

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    // Drive v at the falling edge; the output must hold the previous result until
    // the next rising edge and show exp just after it.
    task automatic apply(input string tag, input logic [7:0] v, input logic [7:0] exp);
        @(negedge clk);
        morse_array = v;
        #1;
        check({tag, "_hold"}, decoded_char, prev_exp);
        @(posedge clk);
        #1;
        check(tag, decoded_char, exp);
        prev_exp = exp;
    endtask

    initial begin
        rst         = 1'b0;
        morse_array = 8'b00000110;
        repeat (2) @(posedge clk);
        #1;
        check("preload_A", decoded_char, 8'h41);

        // Asynchronous reset between edges must clear at once and hold.
        #2;
        rst = 1'b1;
        #1;
        check("rst_immediate", decoded_char, 8'h00);
        @(posedge clk);
        #1;
        check("rst_hold", decoded_char, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_release_before_edge", decoded_char, 8'h00);
        @(posedge clk);
        #1;
        check("first_after_rst", decoded_char, 8'h41);
        prev_exp = 8'h41;

        apply("seq_A", 8'b00000110, 8'h41);
        apply("seq_B", 8'b10010101, 8'h42);
        apply("seq_E", 8'b00000001, 8'h45);
        apply("seq_H", 8'b01010101, 8'h48);
        apply("all_ones", 8'b11111111, 8'h3F);
        apply("has_11", 8'b01101101, 8'h3F);
        apply("gap", 8'b01000001, 8'h3F);
        apply("P", 8'b01101001, 8'h50);
        apply("T", 8'b00000010, 8'h54);
        apply("unassigned", 8'b01011010, 8'h3F);
        apply("empty", 8'h00, 8'h00);

        // Input changing mid-cycle must not reach the output before the edge.
        @(negedge clk);
        morse_array = 8'b00000110;
        #2;
        morse_array = 8'b00000010;
        #1;
        check("midcycle_hold", decoded_char, 8'h00);
        @(posedge clk);
        #1;
        check("midcycle_load", decoded_char, 8'h54);
        prev_exp = 8'h54;

        for (int v = 0; v < 256; v++) begin
            apply("sweep", 8'(v), ref_decode(8'(v)));
        end

        for (int n = 0; n < 200; n++) begin
            logic [7:0] r;
            r = 8'($urandom_range(255));
            apply("random", r, ref_decode(r));
        end

        // Reset asserted mid-operation overrides the pending result.
        @(negedge clk);
        morse_array = 8'b01010101;
        #2;
        rst = 1'b1;
        #1;
        check("rst_midop", decoded_char, 8'h00);
        @(posedge clk);
        #1;
        check("rst_midop_hold", decoded_char, 8'h00);
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
